mem_arbiter: RTL and testbench

- Shares the single external memory port between instruction fetch and data load/store. The multi-cycle core can then run against one single-port RAM.
- Sits between the core (fetch side: pc/ce; data side: mem-stage addr/we/store data) and the RAM.
- The RAM may insert wait states through a ready handshake.
- Provides fair arbitration on conflict and a bus-timeout error so a dead slave cannot hang the core.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_wait_timer.sv | 26 ++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory-port arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;
  localparam int TO_W_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_ID_IF = 1'b0,
    GNT_ID_D  = 1'b1
  } grant_id_e;

  // On a conflict the requester that did not win last time goes first.
  function automatic grant_id_e pick_winner(input logic      elig_if,
                                            input logic      elig_d,
                                            input grant_id_e last);
    if (elig_if && elig_d) return (last == GNT_ID_IF) ? GNT_ID_D : GNT_ID_IF;
    else if (elig_d)       return GNT_ID_D;
    else                   return GNT_ID_IF;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side (fetch + data) and memory-side bus signals of the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// Counts wait cycles of the current memory access; flags the last tolerated one.
module mem_arbiter_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TO_W-1:0] TERM = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  end

  // TIMEOUT of zero means the access may wait forever.
  assign o_expired = (TIMEOUT != 0) && (r_count == TERM);

endmodule

// File: rtl/mem_arbiter.sv
// Fair fetch/data arbiter in front of a single-port RAM with ready wait states
// and a bus timeout.
//   state  | meaning
//   IDLE   | no access in flight; arbitrate eligible requesters
//   GNT_IF | fetch owns the memory port, waiting for m_ready
//   GNT_D  | load/store owns the memory port, waiting for m_ready
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e        r_state,    w_state_nxt;
  grant_id_e         r_last,     w_last_nxt;
  logic              r_m_req,    w_m_req_nxt;
  logic              r_m_we,     w_m_we_nxt;
  logic [ADDR_W-1:0] r_m_addr,   w_m_addr_nxt;
  logic [DATA_W-1:0] r_m_wdata,  w_m_wdata_nxt;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata,  w_d_rdata_nxt;
  logic              r_if_ack,   w_if_ack_nxt;
  logic              r_if_err,   w_if_err_nxt;
  logic              r_d_ack,    w_d_ack_nxt;
  logic              r_d_err,    w_d_err_nxt;

  logic              w_elig_if, w_elig_d;
  grant_id_e         w_winner;
  logic              w_tmr_clear, w_tmr_enable, w_tmr_expired;

  // A requester still holds req during its own ack/err cycle; ignore it then.
  assign w_elig_if = bus.if_req & ~(r_if_ack | r_if_err);
  assign w_elig_d  = bus.d_req  & ~(r_d_ack  | r_d_err);
  assign w_winner  = pick_winner(w_elig_if, w_elig_d, r_last);

  mem_arbiter_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_tmr_clear),
    .i_enable  (w_tmr_enable),
    .o_expired (w_tmr_expired)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_m_req_nxt    = r_m_req;
    w_m_we_nxt     = r_m_we;
    w_m_addr_nxt   = r_m_addr;
    w_m_wdata_nxt  = r_m_wdata;
    w_if_rdata_nxt = r_if_rdata;
    w_d_rdata_nxt  = r_d_rdata;
    w_if_ack_nxt   = 1'b0;
    w_if_err_nxt   = 1'b0;
    w_d_ack_nxt    = 1'b0;
    w_d_err_nxt    = 1'b0;
    w_tmr_clear    = 1'b0;
    w_tmr_enable   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_elig_if || w_elig_d) begin
          w_last_nxt  = w_winner;
          w_m_req_nxt = 1'b1;
          w_tmr_clear = 1'b1;
          if (w_winner == GNT_ID_D) begin
            w_state_nxt   = GNT_D;
            w_m_addr_nxt  = bus.d_addr;
            w_m_we_nxt    = bus.d_we;
            w_m_wdata_nxt = bus.d_wdata;
          end else begin
            w_state_nxt  = GNT_IF;
            w_m_addr_nxt = bus.if_addr;
            w_m_we_nxt   = 1'b0;
          end
        end
      end

      GNT_IF, GNT_D: begin
        if (bus.m_ready) begin
          w_state_nxt = IDLE;
          w_m_req_nxt = 1'b0;
          w_m_we_nxt  = 1'b0;
          if (r_state == GNT_IF) begin
            w_if_ack_nxt   = 1'b1;
            w_if_rdata_nxt = bus.m_rdata;
          end else begin
            w_d_ack_nxt = 1'b1;
            if (!r_m_we) w_d_rdata_nxt = bus.m_rdata;
          end
        end else begin
          w_tmr_enable = 1'b1;
          if (w_tmr_expired) begin
            w_state_nxt = IDLE;
            w_m_req_nxt = 1'b0;
            w_m_we_nxt  = 1'b0;
            if (r_state == GNT_IF) w_if_err_nxt = 1'b1;
            else                   w_d_err_nxt  = 1'b1;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_last     <= GNT_ID_IF;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_if_err   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_d_err    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_m_req    <= w_m_req_nxt;
      r_m_we     <= w_m_we_nxt;
      r_m_addr   <= w_m_addr_nxt;
      r_m_wdata  <= w_m_wdata_nxt;
      r_if_rdata <= w_if_rdata_nxt;
      r_d_rdata  <= w_d_rdata_nxt;
      r_if_ack   <= w_if_ack_nxt;
      r_if_err   <= w_if_err_nxt;
      r_d_ack    <= w_d_ack_nxt;
      r_d_err    <= w_d_err_nxt;
    end
  end

  assign bus.m_req    = r_m_req;
  assign bus.m_we     = r_m_we;
  assign bus.m_addr   = r_m_addr;
  assign bus.m_wdata  = r_m_wdata;
  assign bus.if_rdata = r_if_rdata;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.if_ack   = r_if_ack;
  assign bus.if_err   = r_if_err;
  assign bus.d_ack    = r_d_ack;
  assign bus.d_err    = r_d_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized run against a rule-level arbiter model.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [logic [31:0]];

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO),
    .TO_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0; bus.if_addr = '0;
    bus.d_req   = 1'b0; bus.d_we    = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_rdata = '0;   bus.m_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
  endtask

  // Single zero-wait fetch (is_d=0) or load (is_d=1), requester drops after ack.
  task automatic do_zero_wait(input bit is_d, input logic [31:0] a, input logic [31:0] rd);
    if (is_d) begin bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = a; end
    else      begin bus.if_req = 1'b1; bus.if_addr = a; end
    cyc(); bus.m_ready = 1'b1; bus.m_rdata = rd;
    cyc(); bus.m_ready = 1'b0;
    cyc(); bus.if_req = 1'b0; bus.d_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({bus.m_req, bus.m_we, bus.if_ack, bus.if_err, bus.d_ack, bus.d_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 000000", {bus.m_req, bus.m_we, bus.if_ack, bus.if_err, bus.d_ack, bus.d_err}); end
    checks++; if (bus.m_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr: got %h, expected 0", bus.m_addr); end
    checks++; if (bus.m_wdata !== 32'h0) begin errors++; $display("FAIL reset_m_wdata: got %h, expected 0", bus.m_wdata); end
    checks++; if (bus.if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata: got %h, expected 0", bus.if_rdata); end
    checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %h, expected 0", bus.d_rdata); end
    repeat (2) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL reset_idle_mreq: got %b, expected 0", bus.m_req); end
  endtask

  task automatic test_fetch_basic();
    apply_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    cyc();
    checks++; if ({bus.m_req, bus.m_we, bus.m_addr} !== {1'b1, 1'b0, 32'h0000_0010}) begin
      errors++; $display("FAIL fetch_grant: got req=%b we=%b addr=%h, expected 1 0 00000010", bus.m_req, bus.m_we, bus.m_addr); end
    bus.m_ready = 1'b1; bus.m_rdata = 32'h0000_0513;
    cyc();
    checks++; if ({bus.if_ack, bus.m_req} !== 2'b10) begin
      errors++; $display("FAIL fetch_ack: got ack=%b mreq=%b, expected 1 0", bus.if_ack, bus.m_req); end
    checks++; if (bus.if_rdata !== 32'h0000_0513) begin errors++; $display("FAIL fetch_rdata: got %h, expected 00000513", bus.if_rdata); end
    bus.m_ready = 1'b0; bus.m_rdata = 32'hFFFF_FFFF;
    cyc();
    checks++; if ({bus.if_ack, bus.m_req} !== 2'b00) begin
      errors++; $display("FAIL fetch_ack_pulse: got ack=%b mreq=%b, expected 0 0", bus.if_ack, bus.m_req); end
    bus.if_req = 1'b0;
    cyc();
  endtask

  task automatic test_conflict();
    apply_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    cyc();
    checks++; if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL conflict_first_data: got req=%b addr=%h, expected 1 00000100", bus.m_req, bus.m_addr); end
    bus.m_ready = 1'b1; bus.m_rdata = 32'h1111_0100;
    cyc();
    checks++; if ({bus.d_ack, bus.if_ack, bus.d_rdata} !== {2'b10, 32'h1111_0100}) begin
      errors++; $display("FAIL conflict_d_ack: got dack=%b iack=%b drdata=%h, expected 1 0 11110100", bus.d_ack, bus.if_ack, bus.d_rdata); end
    bus.m_ready = 1'b0;
    cyc();
    checks++; if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL conflict_then_fetch: got req=%b addr=%h, expected 1 00000040", bus.m_req, bus.m_addr); end
    bus.d_req = 1'b0; bus.m_ready = 1'b1; bus.m_rdata = 32'h2222_0040;
    cyc();
    checks++; if ({bus.if_ack, bus.d_ack, bus.if_rdata} !== {2'b10, 32'h2222_0040}) begin
      errors++; $display("FAIL conflict_if_ack: got iack=%b dack=%b irdata=%h, expected 1 0 22220040", bus.if_ack, bus.d_ack, bus.if_rdata); end
    bus.m_ready = 1'b0;
    cyc(); bus.if_req = 1'b0;
    cyc();
    // Fetch won most recently, so the next conflict goes to data.
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_addr = 32'h104;
    cyc();
    checks++; if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h104}) begin
      errors++; $display("FAIL conflict_alternate: got req=%b addr=%h, expected 1 00000104", bus.m_req, bus.m_addr); end
    idle_inputs();
  endtask

  task automatic test_store_wait();
    int acks;
    apply_reset();
    do_zero_wait(1'b1, 32'h1F0, 32'hCAFE_F00D);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata} !== {2'b11, 32'h200, 32'hDEAD_BEEF}) begin
        errors++; $display("FAIL store_hold[%0d]: got req=%b we=%b addr=%h wdata=%h, expected 1 1 00000200 deadbeef", i, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata); end
      if (bus.d_ack) acks++;
      bus.m_ready = (i == 3); bus.m_rdata = 32'h1234_5678;
    end
    cyc();
    if (bus.d_ack) acks++;
    checks++; if ({bus.m_req, bus.m_we} !== 2'b00) begin
      errors++; $display("FAIL store_release: got req=%b we=%b, expected 0 0", bus.m_req, bus.m_we); end
    checks++; if (bus.d_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL store_rdata_hold: got %h, expected cafef00d", bus.d_rdata); end
    bus.m_ready = 1'b0;
    cyc(); if (bus.d_ack) acks++;
    bus.d_req = 1'b0;
    cyc(); if (bus.d_ack) acks++;
    checks++; if (acks != 1) begin errors++; $display("FAIL store_ack_count: got %0d, expected 1", acks); end
  endtask

  task automatic test_timeout();
    int mreq_cyc, errs, acks;
    bit drop;
    apply_reset();
    do_zero_wait(1'b0, 32'h2F0, 32'h0000_ABCD);
    bus.if_req = 1'b1; bus.if_addr = 32'h300; bus.m_rdata = 32'hFFFF_FFFF;
    mreq_cyc = 0; errs = 0; acks = 0; drop = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (drop) bus.if_req = 1'b0;
      if (bus.m_req) mreq_cyc++;
      if (bus.if_ack) acks++;
      if (bus.if_err) begin errs++; drop = 1'b1; end
    end
    checks++; if (mreq_cyc != TMO) begin errors++; $display("FAIL timeout_mreq_cycles: got %0d, expected %0d", mreq_cyc, TMO); end
    checks++; if (errs != 1) begin errors++; $display("FAIL timeout_err_count: got %0d, expected 1", errs); end
    checks++; if (acks != 0) begin errors++; $display("FAIL timeout_ack_count: got %0d, expected 0", acks); end
    checks++; if (bus.if_rdata !== 32'h0000_ABCD) begin errors++; $display("FAIL timeout_rdata_hold: got %h, expected 0000abcd", bus.if_rdata); end
    idle_inputs();
  endtask

  task automatic test_ready_on_timeout();
    apply_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h340;
    for (int i = 1; i <= TMO; i++) begin
      cyc();
      if (i == TMO) begin
        checks++; if (bus.m_req !== 1'b1) begin errors++; $display("FAIL rto_still_waiting: got %b, expected 1", bus.m_req); end
      end
      bus.m_ready = (i == TMO); bus.m_rdata = 32'h7777_0340;
    end
    cyc();
    checks++; if ({bus.if_ack, bus.if_err} !== 2'b10) begin
      errors++; $display("FAIL rto_ack_wins: got ack=%b err=%b, expected 1 0", bus.if_ack, bus.if_err); end
    checks++; if (bus.if_rdata !== 32'h7777_0340) begin errors++; $display("FAIL rto_rdata: got %h, expected 77770340", bus.if_rdata); end
    bus.m_ready = 1'b0;
    cyc();
    checks++; if (bus.if_err !== 1'b0) begin errors++; $display("FAIL rto_late_err: got %b, expected 0", bus.if_err); end
    idle_inputs();
    cyc();
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    do_zero_wait(1'b0, 32'h4F0, 32'h0BAD_F00D);
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600;
    cyc();
    checks++; if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h600}) begin
      errors++; $display("FAIL rmid_grant_d: got req=%b addr=%h, expected 1 00000600", bus.m_req, bus.m_addr); end
    bus.m_ready = 1'b0;
    cyc();
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.m_req, bus.d_ack, bus.d_err, bus.if_ack} !== 4'b0) begin
      errors++; $display("FAIL rmid_async_ctrl: got %b, expected 0000", {bus.m_req, bus.d_ack, bus.d_err, bus.if_ack}); end
    checks++; if ({bus.m_addr, bus.if_rdata} !== 64'h0) begin
      errors++; $display("FAIL rmid_async_data: got addr=%h irdata=%h, expected 0 0", bus.m_addr, bus.if_rdata); end
    idle_inputs();
    bus.m_ready = 1'b1;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if ({bus.d_ack, bus.m_req} !== 2'b00) begin
        errors++; $display("FAIL rmid_no_stale[%0d]: got dack=%b mreq=%b, expected 0 0", i, bus.d_ack, bus.m_req); end
    end
    bus.m_ready = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    bus.d_req = 1'b1; bus.d_addr = 32'h600;
    cyc();
    checks++; if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h600}) begin
      errors++; $display("FAIL rmid_conflict_to_data: got req=%b addr=%h, expected 1 00000600", bus.m_req, bus.m_addr); end
    idle_inputs();
  endtask

  task automatic test_random(input int ncyc);
    logic        rq_req [2];
    logic [31:0] rq_addr [2];
    logic        rq_we;
    logic [31:0] rq_wdata;
    logic        drop [2];
    logic        pv_req [2];
    logic [31:0] pv_addr [2];
    logic        pv_we, pv_ready;
    logic [31:0] pv_wdata, pv_rdata;
    logic        busy, el0, el1, got;
    int          owner, last_win, cnt, n_obs, wt, r;
    logic [31:0] ex_addr, ex_wdata;
    logic        ex_we;
    logic [31:0] ex_rdata [2];
    logic        ex_ack [2], ex_err [2], prev_ae [2];
    logic [3:0]  exp_ae, got_ae;

    apply_reset();
    mem.delete();
    for (int i = 0; i < 2; i++) begin
      rq_req[i] = 1'b0; rq_addr[i] = '0; drop[i] = 1'b0; pv_req[i] = 1'b0;
      pv_addr[i] = '0; ex_rdata[i] = '0; prev_ae[i] = 1'b0;
    end
    rq_we = 1'b0; rq_wdata = '0; pv_we = 1'b0; pv_wdata = '0; pv_ready = 1'b0; pv_rdata = '0;
    busy = 1'b0; owner = 0; last_win = 0; cnt = 0; n_obs = 0; wt = 0;
    ex_addr = '0; ex_wdata = '0; ex_we = 1'b0;

    for (int c = 0; c < ncyc; c++) begin
      cyc();
      ex_ack[0] = 1'b0; ex_ack[1] = 1'b0; ex_err[0] = 1'b0; ex_err[1] = 1'b0;
      if (!busy) begin
        el0 = pv_req[0] && !prev_ae[0];
        el1 = pv_req[1] && !prev_ae[1];
        if (el0 || el1) begin
          owner    = (el0 && el1) ? 1 - last_win : (el1 ? 1 : 0);
          last_win = owner;
          busy     = 1'b1;
          cnt      = 1;
          ex_addr  = pv_addr[owner];
          ex_we    = (owner == 1) ? pv_we : 1'b0;
          ex_wdata = pv_wdata;
        end
      end else if (pv_ready) begin
        ex_ack[owner] = 1'b1;
        if (!ex_we) ex_rdata[owner] = pv_rdata;
        busy = 1'b0;
      end else if (cnt == TMO) begin
        ex_err[owner] = 1'b1;
        busy = 1'b0;
      end else begin
        cnt++;
      end

      checks++; if (bus.m_req !== busy) begin errors++; $display("FAIL rnd_m_req @%0d: got %b, expected %b", c, bus.m_req, busy); end
      if (busy) begin
        checks++; if ({bus.m_addr, bus.m_we} !== {ex_addr, ex_we}) begin
          errors++; $display("FAIL rnd_m_addr_we @%0d: got %h/%b, expected %h/%b", c, bus.m_addr, bus.m_we, ex_addr, ex_we); end
        if (ex_we) begin
          checks++; if (bus.m_wdata !== ex_wdata) begin errors++; $display("FAIL rnd_m_wdata @%0d: got %h, expected %h", c, bus.m_wdata, ex_wdata); end
        end
      end
      exp_ae = {ex_ack[0], ex_err[0], ex_ack[1], ex_err[1]};
      got_ae = {bus.if_ack, bus.if_err, bus.d_ack, bus.d_err};
      checks++; if (got_ae !== exp_ae) begin errors++; $display("FAIL rnd_ack_err @%0d: got %b, expected %b", c, got_ae, exp_ae); end
      checks++; if (bus.if_rdata !== ex_rdata[0]) begin errors++; $display("FAIL rnd_if_rdata @%0d: got %h, expected %h", c, bus.if_rdata, ex_rdata[0]); end
      checks++; if (bus.d_rdata !== ex_rdata[1]) begin errors++; $display("FAIL rnd_d_rdata @%0d: got %h, expected %h", c, bus.d_rdata, ex_rdata[1]); end
      prev_ae[0] = ex_ack[0] | ex_err[0];
      prev_ae[1] = ex_ack[1] | ex_err[1];

      for (int i = 0; i < 2; i++) begin
        got = (i == 0) ? (bus.if_ack | bus.if_err) : (bus.d_ack | bus.d_err);
        if (got) drop[i] = 1'b1;
        else if (drop[i]) begin drop[i] = 1'b0; rq_req[i] = 1'b0; end
        else if (!rq_req[i] && $urandom_range(0, 99) < 45) begin
          rq_req[i]  = 1'b1;
          rq_addr[i] = 32'h0000_1000 + ($urandom_range(0, 7) << 2);
          if (i == 1) begin rq_we = 1'($urandom_range(0, 1)); rq_wdata = $urandom; end
        end
      end
      bus.if_req = rq_req[0]; bus.if_addr = rq_addr[0];
      bus.d_req  = rq_req[1]; bus.d_addr  = rq_addr[1]; bus.d_we = rq_we; bus.d_wdata = rq_wdata;

      if (bus.m_req) n_obs++; else n_obs = 0;
      if (n_obs == 1) begin
        r  = $urandom_range(0, 9);
        wt = (r < 6) ? $urandom_range(0, 3) : ((r < 8) ? TMO - 1 : 1000);
      end
      if (n_obs != 0 && n_obs == wt + 1) begin
        bus.m_ready = 1'b1;
        if (bus.m_we) begin mem[bus.m_addr] = bus.m_wdata; bus.m_rdata = $urandom; end
        else bus.m_rdata = mem_rd(bus.m_addr);
      end else begin
        bus.m_ready = (n_obs != 0) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.m_rdata = $urandom;
      end

      for (int i = 0; i < 2; i++) begin pv_req[i] = rq_req[i]; pv_addr[i] = rq_addr[i]; end
      pv_we = rq_we; pv_wdata = rq_wdata; pv_ready = bus.m_ready; pv_rdata = bus.m_rdata;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_conflict();
    test_store_wait();
    test_timeout();
    test_ready_on_timeout();
    test_reset_mid_access();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
